// File: rtl/bist_golden_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : bist_golden_recorder
//  Description : Golden-response recorder for the BIST compare path. Steps the
//                ALU through ALU_Sel 0..15 (wrapping), strobes the pattern
//                generators, stores each {ALU_Out, CarryOut} response into an
//                internal memory and keeps a rotate-XOR signature of the image.
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_golden_recorder #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vecs,
    input  logic [DATA_W-1:0] resp_in,
    output logic [3:0]        alu_sel,
    output logic              vec_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic [DATA_W-1:0] signature
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_capture = 2'd1;
    localparam logic [1:0] c_done    = 2'd2;

    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W:0]   r_tgt;
    logic [ADDR_W:0]   w_tgt_clip;
    logic [ADDR_W:0]   w_cnt_inc;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_wr_count;
    logic [3:0]        r_alu_sel;
    logic [DATA_W-1:0] r_signature;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_accept_start;
    logic              w_capturing;

    // A start is honoured in IDLE and DONE only; a run in flight cannot be restarted.
    assign w_accept_start = start && (r_state != c_capture);
    assign w_tgt_clip     = (num_vecs > c_depth) ? c_depth : num_vecs;
    assign w_cnt_inc      = r_wr_count + c_cnt_one;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: a zero-length request goes straight to DONE; capture ends on the tgt-th write.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle, c_done: begin
                if (start) begin
                    w_next_state = (num_vecs == '0) ? c_done : c_capture;
                end
            end
            c_capture: begin
                if (w_cnt_inc == r_tgt) begin
                    w_next_state = c_done;
                end
            end
            default: w_next_state = c_idle;
        endcase
    end

    // Status and generator strobe decoded straight from the state.
    always_comb begin
        w_capturing = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_capture: w_capturing = 1'b1;
            c_done:    done        = 1'b1;
            default:   ;
        endcase
        busy   = w_capturing;
        vec_en = w_capturing;
    end

    // Run bookkeeping: cleared and target latched on an accepted start, advanced per write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_sel   <= '0;
            r_wr_addr   <= '0;
            r_wr_count  <= '0;
            r_signature <= '0;
            r_tgt       <= '0;
        end else if (w_accept_start) begin
            r_alu_sel   <= '0;
            r_wr_addr   <= '0;
            r_wr_count  <= '0;
            r_signature <= '0;
            r_tgt       <= w_tgt_clip;
        end else if (w_capturing) begin
            r_alu_sel   <= r_alu_sel + 4'd1;
            r_wr_addr   <= r_wr_addr + c_addr_one;
            r_wr_count  <= w_cnt_inc;
            r_signature <= {r_signature[DATA_W-2:0], r_signature[DATA_W-1]} ^ resp_in;
        end
    end

    // Golden image store; deliberately not reset so an aborted run keeps its words.
    always_ff @(posedge clk) begin
        if (w_capturing) begin
            r_mem[r_wr_addr] <= resp_in;
        end
    end

    // Registered readout; sees the pre-write contents when addresses collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign alu_sel   = r_alu_sel;
    assign wr_count  = r_wr_count;
    assign signature = r_signature;
    assign rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_bist_golden_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bist_golden_recorder
//  Description : Self-checking bench for bist_golden_recorder. A 16-entry ALU
//                stub maps alu_sel to a response; a reference model derives the
//                expected image, count and signature from the run length alone.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_golden_recorder;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] num_vecs;
    logic [8:0] resp_in;
    logic [3:0] alu_sel;
    logic       vec_en;
    logic [7:0] rd_addr;
    logic [8:0] rd_data;
    logic       busy;
    logic       done;
    logic [8:0] wr_count;
    logic [8:0] signature;

    logic [8:0] stub [16];
    logic       ovr;

    logic [8:0] exp_mem [256];
    bit         known   [256];
    logic [8:0] exp_sig;
    int         exp_cnt;
    int         exp_sel;

    int total;
    int bad;

    bist_golden_recorder #(.DATA_W(9), .ADDR_W(8), .DEPTH(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_vecs  (num_vecs),
        .resp_in   (resp_in),
        .alu_sel   (alu_sel),
        .vec_en    (vec_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count),
        .signature (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU stand-in; ovr forces a marker value to expose stray writes.
    always_comb begin
        resp_in = ovr ? 9'h1AA : stub[alu_sel];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        logic [31:0] rnd;
        for (int i = 0; i < 16; i++) begin
            rnd = $urandom;
            stub[i] = rnd[8:0];
        end
    endtask

    // Reference: run of n requested vectors writes min(n,256) responses stub[k mod 16].
    task automatic model_run(input int n);
        int tgt;
        tgt = (n > 256) ? 256 : n;
        exp_sig = '0;
        for (int k = 0; k < tgt; k++) begin
            exp_mem[k] = stub[k % 16];
            known[k]   = 1'b1;
            exp_sig    = {exp_sig[7:0], exp_sig[8]} ^ stub[k % 16];
        end
        exp_cnt = tgt;
        exp_sel = tgt % 16;
    endtask

    // Pulse start, then count busy cycles (bounded); optionally poke start mid-run.
    task automatic do_run(input int n, input bit mid_start, output int busy_cycles, output int strobe_err);
        num_vecs = 9'(n);
        start    = 1'b1;
        tick();
        start       = 1'b0;
        busy_cycles = 0;
        strobe_err  = 0;
        for (int c = 0; c < 400 && busy; c++) begin
            busy_cycles++;
            if (vec_en !== 1'b1) strobe_err++;
            if (mid_start && c == 1) begin
                start    = 1'b1;
                num_vecs = 9'd16;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        if (vec_en !== 1'b0) strobe_err++;
    endtask

    task automatic rd_check(input string tag, input int a);
        rd_addr = 8'(a);
        tick();
        if (known[a]) chk(tag, {23'd0, rd_data}, {23'd0, exp_mem[a]});
    endtask

    initial begin
        int bc;
        int se;
        logic [8:0] old3;
        logic [31:0] rnd;
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        num_vecs = '0;
        rd_addr  = '0;
        ovr      = 1'b0;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        for (int i = 0; i < 16; i++) stub[i] = 9'(i * 3);

        // Reset values.
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_vec_en", {31'd0, vec_en}, 0);
        chk("rst_alu_sel", {28'd0, alu_sel}, 0);
        chk("rst_wr_count", {23'd0, wr_count}, 0);
        chk("rst_signature", {23'd0, signature}, 0);
        chk("rst_rd_data", {23'd0, rd_data}, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Sixteen vectors with the alu_sel*3 stub.
        do_run(16, 1'b0, bc, se);
        model_run(16);
        chk("r16_busy_cycles", bc, 16);
        chk("r16_strobe", se, 0);
        chk("r16_wr_count", {23'd0, wr_count}, exp_cnt);
        chk("r16_done", {31'd0, done}, 1);
        chk("r16_alu_sel", {28'd0, alu_sel}, exp_sel);
        chk("r16_signature", {23'd0, signature}, {23'd0, exp_sig});
        for (int a = 0; a < 16; a++) rd_check("r16_mem", a);

        // Oversized request clipped to the full memory.
        fill_random();
        do_run(300, 1'b0, bc, se);
        ovr = 1'b1;
        model_run(300);
        chk("r300_busy_cycles", bc, 256);
        chk("r300_strobe", se, 0);
        tick();
        chk("r300_wr_count", {23'd0, wr_count}, 256);
        chk("r300_alu_sel", {28'd0, alu_sel}, exp_sel);
        chk("r300_signature", {23'd0, signature}, {23'd0, exp_sig});
        rd_check("r300_mem0_no_rewrite", 0);
        rd_check("r300_mem255", 255);
        for (int i = 0; i < 4; i++) begin
            rnd = $urandom;
            rd_check("r300_mem_rand", int'(rnd[7:0]));
        end
        ovr = 1'b0;

        // Zero-length run: straight to DONE, no writes.
        do_run(0, 1'b0, bc, se);
        chk("r0_busy_cycles", bc, 0);
        chk("r0_done", {31'd0, done}, 1);
        chk("r0_wr_count", {23'd0, wr_count}, 0);
        tick();
        tick();
        chk("r0_busy_stays_low", {31'd0, busy}, 0);
        rd_check("r0_mem0_kept", 0);
        rd_check("r0_mem255_kept", 255);

        // Constant response signatures; start during CAPTURE ignored.
        for (int i = 0; i < 16; i++) stub[i] = 9'h001;
        do_run(9, 1'b0, bc, se);
        model_run(9);
        chk("c9_signature", {23'd0, signature}, 32'h1FF);
        chk("c9_signature_model", {23'd0, signature}, {23'd0, exp_sig});
        do_run(4, 1'b1, bc, se);
        model_run(4);
        chk("c4_busy_cycles", bc, 4);
        chk("c4_signature", {23'd0, signature}, 32'h00F);
        chk("c4_wr_count", {23'd0, wr_count}, 4);

        // Reset part-way through a ten-vector run.
        fill_random();
        num_vecs = 9'd10;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        for (int k = 0; k < 5; k++) exp_mem[k] = stub[k];
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_vec_en", {31'd0, vec_en}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_alu_sel", {28'd0, alu_sel}, 0);
        chk("abort_wr_count", {23'd0, wr_count}, 0);
        chk("abort_signature", {23'd0, signature}, 0);
        chk("abort_rd_data", {23'd0, rd_data}, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 6; a++) rd_check("abort_mem_kept", a);
        do_run(10, 1'b0, bc, se);
        model_run(10);
        chk("rerun_busy_cycles", bc, 10);
        chk("rerun_wr_count", {23'd0, wr_count}, exp_cnt);
        chk("rerun_signature", {23'd0, signature}, {23'd0, exp_sig});
        for (int a = 0; a < 10; a++) rd_check("rerun_mem", a);

        // Read-before-write on address 3.
        old3 = exp_mem[3];
        fill_random();
        stub[3]  = ~old3;
        rd_addr  = 8'd3;
        num_vecs = 9'd8;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("rbw_old", {23'd0, rd_data}, {23'd0, old3});
        tick();
        chk("rbw_new", {23'd0, rd_data}, {23'd0, stub[3]});
        for (int c = 0; c < 40 && busy; c++) tick();
        model_run(8);
        chk("rbw_done", {31'd0, done}, 1);
        chk("rbw_wr_count", {23'd0, wr_count}, exp_cnt);
        chk("rbw_signature", {23'd0, signature}, {23'd0, exp_sig});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
